decode_stage: RTL and testbench

//  RV32I decode stage. Sits between fetch and execute and drives the register-file read port.

---
 rtl/decode_stage_pkg.sv | 65 ++++++
 rtl/decode_stage_scoreboard.sv | 44 ++++
 rtl/decode_stage.sv | 103 ++++++++++
 tb/tb_decode_stage.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode definitions: opcodes, decode-stage state and records,
// and the combinational field/immediate decoder.
package decode_stage_pkg;

    localparam int DEF_XLEN = 32;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;

    typedef enum logic [1:0] {IDLE, WAIT, OUT} dstate_t;

    typedef struct packed {
        logic [DEF_XLEN-1:0] pc;
        logic [31:0]         instr;
        logic [DEF_XLEN-1:0] imm;
        logic [4:0]          rd;
        logic                rd_used;
    } decoded_t;

    // Register indices not used by the opcode come back as 0 so they never hazard.
    typedef struct packed {
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic                rd_used;
        logic [DEF_XLEN-1:0] imm;
    } fields_t;

    function automatic fields_t decode_fields(input logic [31:0] instr);
        fields_t    f;
        logic [6:0] opc;
        logic       rs1_u;
        logic       rs2_u;
        logic       rd_u;
        opc   = instr[6:0];
        rs1_u = (opc == OP) || (opc == OP_IMM) || (opc == LOAD) || (opc == STORE) ||
                (opc == BRANCH) || (opc == JALR);
        rs2_u = (opc == OP) || (opc == STORE) || (opc == BRANCH);
        rd_u  = (opc == OP) || (opc == OP_IMM) || (opc == LOAD) || (opc == LUI) ||
                (opc == AUIPC) || (opc == JAL) || (opc == JALR);
        f.rs1     = rs1_u ? instr[19:15] : 5'd0;
        f.rs2     = rs2_u ? instr[24:20] : 5'd0;
        f.rd      = rd_u  ? instr[11:7]  : 5'd0;
        f.rd_used = rd_u && (instr[11:7] != 5'd0);
        case (opc)
            OP_IMM, LOAD, JALR: f.imm = {{20{instr[31]}}, instr[31:20]};
            STORE:              f.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            BRANCH:             f.imm = {{19{instr[31]}}, instr[31], instr[7],
                                         instr[30:25], instr[11:8], 1'b0};
            LUI, AUIPC:         f.imm = {instr[31:12], 12'd0};
            JAL:                f.imm = {{11{instr[31]}}, instr[31], instr[19:12],
                                         instr[20], instr[30:21], 1'b0};
            default:            f.imm = '0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/decode_stage_scoreboard.sv
// Busy scoreboard: one bit per architectural register, cleared by writeback and set
// by issue (set wins on the same index), with three hazard query ports.
module decode_stage_scoreboard #(
    parameter bit BYPASS_WB = 1'b1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       clr_en,
    input  logic [4:0] clr_addr,
    input  logic       set_en,
    input  logic [4:0] set_addr,
    input  logic [4:0] q_rs1,
    input  logic [4:0] q_rs2,
    input  logic [4:0] q_rd,
    output logic       haz_rs1,
    output logic       haz_rs2,
    output logic       haz_rd
);

    logic [31:0] busy;
    logic [31:0] busy_nxt;

    function automatic logic hazard(input logic [4:0] r, input logic [31:0] b,
                                    input logic ce, input logic [4:0] ca);
        return (r != 5'd0) && b[r] && !(BYPASS_WB && ce && (ca == r));
    endfunction

    assign haz_rs1 = hazard(q_rs1, busy, clr_en, clr_addr);
    assign haz_rs2 = hazard(q_rs2, busy, clr_en, clr_addr);
    assign haz_rd  = hazard(q_rd,  busy, clr_en, clr_addr);

    always_comb begin
        busy_nxt = busy;
        if (clr_en && (clr_addr != 5'd0)) busy_nxt[clr_addr] = 1'b0;
        if (set_en && (set_addr != 5'd0)) busy_nxt[set_addr] = 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) busy <= '0;
        else       busy <= busy_nxt;
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: holds one instruction, stalls on scoreboard hazards and
// strobes the register-file read one cycle before out_valid.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN      = DEF_XLEN,
    parameter bit BYPASS_WB = 1'b1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_instr,
    input  logic            flush,
    output logic            rf_r_enabled,
    output logic [4:0]      rf_rs1,
    output logic [4:0]      rf_rs2,
    input  logic            wb_enable,
    input  logic [4:0]      wb_addr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rd,
    output logic            out_rd_used
);

    dstate_t  state;
    dstate_t  state_nxt;
    decoded_t held;
    fields_t  dec;
    logic     haz_rs1;
    logic     haz_rs2;
    logic     haz_rd;
    logic     stall;
    logic     accept;
    logic     issue;

    // In IDLE the offered instruction is checked; otherwise the held one.
    assign dec    = decode_fields((state == IDLE) ? in_instr : held.instr);
    assign stall  = haz_rs1 | haz_rs2 | haz_rd;
    assign accept = (state == IDLE) && in_valid && !flush;
    assign issue  = (state == OUT) && out_ready && !flush;

    decode_stage_scoreboard #(.BYPASS_WB(BYPASS_WB)) u_scoreboard (
        .clk      (clk),
        .rstn     (rstn),
        .clr_en   (wb_enable),
        .clr_addr (wb_addr),
        .set_en   (issue && held.rd_used),
        .set_addr (held.rd),
        .q_rs1    (dec.rs1),
        .q_rs2    (dec.rs2),
        .q_rd     (dec.rd),
        .haz_rs1  (haz_rs1),
        .haz_rs2  (haz_rs2),
        .haz_rd   (haz_rd)
    );

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt    = state;
        rf_r_enabled = 1'b0;
        case (state)
            IDLE: if (accept) begin
                rf_r_enabled = !stall;
                state_nxt    = stall ? WAIT : OUT;
            end
            WAIT: if (flush) begin
                state_nxt = IDLE;
            end else if (!stall) begin
                rf_r_enabled = 1'b1;
                state_nxt    = OUT;
            end
            OUT:  if (flush || out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
            held  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) held <= '{pc: in_pc, instr: in_instr, imm: dec.imm,
                                  rd: dec.rd, rd_used: dec.rd_used};
        end
    end

    assign in_ready    = (state == IDLE);
    assign out_valid   = (state == OUT) && !flush;
    assign rf_rs1      = rf_r_enabled ? dec.rs1 : 5'd0;
    assign rf_rs2      = rf_r_enabled ? dec.rs2 : 5'd0;
    assign out_pc      = held.pc;
    assign out_instr   = held.instr;
    assign out_imm     = held.imm;
    assign out_rd      = held.rd;
    assign out_rd_used = held.rd_used;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: one instance with writeback bypass, one without.
module tb_decode_stage;

    localparam logic [31:0] I_ADDI_X1 = 32'h0050_0093;  // addi x1,x0,5
    localparam logic [31:0] I_ADD_X2  = 32'h0010_8133;  // add  x2,x1,x1
    localparam logic [31:0] I_ADDI_X2 = 32'h0011_0113;  // addi x2,x2,1
    localparam logic [31:0] I_SW      = 32'hFE31_2E23;  // sw   x3,-4(x2)
    localparam logic [31:0] I_BEQ     = 32'h0000_0463;  // beq  x0,x0,+8
    localparam logic [31:0] I_LUI     = 32'h1234_52B7;  // lui  x5,0x12345

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid, in_ready, flush, rf_r_enabled, wb_enable, out_valid, out_ready, out_rd_used;
    logic [31:0] in_pc, in_instr, out_pc, out_instr, out_imm;
    logic [4:0]  rf_rs1, rf_rs2, wb_addr, out_rd;

    logic        nb_in_valid, nb_in_ready, nb_flush, nb_rf_r_enabled, nb_wb_enable;
    logic        nb_out_valid, nb_out_ready, nb_out_rd_used;
    logic [31:0] nb_in_pc, nb_in_instr, nb_out_pc, nb_out_instr, nb_out_imm;
    logic [4:0]  nb_rf_rs1, nb_rf_rs2, nb_wb_addr, nb_out_rd;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .BYPASS_WB(1'b1)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_instr(in_instr), .flush(flush), .rf_r_enabled(rf_r_enabled), .rf_rs1(rf_rs1),
        .rf_rs2(rf_rs2), .wb_enable(wb_enable), .wb_addr(wb_addr), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr), .out_imm(out_imm),
        .out_rd(out_rd), .out_rd_used(out_rd_used)
    );

    decode_stage #(.XLEN(32), .BYPASS_WB(1'b0)) dut_nb (
        .clk(clk), .rstn(rstn), .in_valid(nb_in_valid), .in_ready(nb_in_ready), .in_pc(nb_in_pc),
        .in_instr(nb_in_instr), .flush(nb_flush), .rf_r_enabled(nb_rf_r_enabled),
        .rf_rs1(nb_rf_rs1), .rf_rs2(nb_rf_rs2), .wb_enable(nb_wb_enable), .wb_addr(nb_wb_addr),
        .out_valid(nb_out_valid), .out_ready(nb_out_ready), .out_pc(nb_out_pc),
        .out_instr(nb_out_instr), .out_imm(nb_out_imm), .out_rd(nb_out_rd),
        .out_rd_used(nb_out_rd_used)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [31:0] instr);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = instr;
    endtask

    initial begin
        rstn = 1'b0;
        {in_valid, flush, wb_enable, out_ready} = '0;
        {in_pc, in_instr, wb_addr} = '0;
        {nb_in_valid, nb_flush, nb_wb_enable, nb_out_ready} = '0;
        {nb_in_pc, nb_in_instr, nb_wb_addr} = '0;
        tick();
        tick();
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_rf_r_en", rf_r_enabled, 0);
        check("rst_out_pc", out_pc, 0);
        check("rst_out_rd_used", out_rd_used, 0);
        check("rst_busy", dut.u_scoreboard.busy, 0);
        rstn = 1'b1;
        tick();

        // addi x1,x0,5: same-cycle read, then out_valid held while out_ready stays low
        offer(32'h100, I_ADDI_X1);
        @(negedge clk);
        check("addi_rf_r_en", rf_r_enabled, 1);
        check("addi_rf_rs1", rf_rs1, 0);
        tick();
        in_valid = 1'b0;
        in_instr = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_out_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_rf_r_en", rf_r_enabled, 0);
            check("hold_out_pc", out_pc, 32'h100);
            check("hold_out_imm", out_imm, 5);
            check("hold_out_rd", out_rd, 1);
            check("hold_busy1", dut.u_scoreboard.busy[1], 0);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("acc_out_valid", out_valid, 1);
        tick();
        out_ready = 1'b0;

        // add x2,x1,x1 stalls on x1 until its writeback
        offer(32'h104, I_ADD_X2);
        @(negedge clk);
        check("post_acc_in_ready", in_ready, 1);
        check("post_acc_busy1", dut.u_scoreboard.busy[1], 1);
        check("raw_rf_r_en", rf_r_enabled, 0);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("wait_in_ready", in_ready, 0);
        check("wait_rf_r_en", rf_r_enabled, 0);
        tick();
        wb_enable = 1'b1;
        wb_addr   = 5'd1;
        @(negedge clk);
        check("byp_rf_r_en", rf_r_enabled, 1);
        check("byp_rf_rs1", rf_rs1, 1);
        check("byp_rf_rs2", rf_rs2, 1);
        tick();
        wb_enable = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("add_out_valid", out_valid, 1);
        check("add_out_rd", out_rd, 2);
        check("add_out_imm", out_imm, 0);
        check("add_out_pc", out_pc, 32'h104);
        tick();
        out_ready = 1'b0;

        // flush while in WAIT keeps the scoreboard
        offer(32'h108, I_ADDI_X2);
        @(negedge clk);
        check("busy_after_add", dut.u_scoreboard.busy, 32'h4);
        check("waw_rf_r_en", rf_r_enabled, 0);
        tick();
        in_valid = 1'b0;
        flush    = 1'b1;
        @(negedge clk);
        check("flush_wait_in_ready", in_ready, 0);
        check("flush_rf_r_en", rf_r_enabled, 0);
        tick();
        flush = 1'b0;
        // flush in IDLE drops the accept; writeback frees x2 in the same cycle
        offer(32'h10C, I_ADDI_X1);
        flush     = 1'b1;
        wb_enable = 1'b1;
        wb_addr   = 5'd2;
        @(negedge clk);
        check("flushed_in_ready", in_ready, 1);
        check("flushed_out_valid", out_valid, 0);
        check("flushed_busy2", dut.u_scoreboard.busy[2], 1);
        tick();
        {in_valid, flush, wb_enable} = '0;

        // sw x3,-4(x2): no destination, negative S immediate
        offer(32'h200, I_SW);
        @(negedge clk);
        check("idle_drop_out_valid", out_valid, 0);
        check("wb_clear_busy", dut.u_scoreboard.busy, 0);
        check("sw_rf_r_en", rf_r_enabled, 1);
        check("sw_rf_rs1", rf_rs1, 2);
        check("sw_rf_rs2", rf_rs2, 3);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("sw_out_rd_used", out_rd_used, 0);
        check("sw_out_rd", out_rd, 0);
        check("sw_out_imm", out_imm, 32'hFFFF_FFFC);
        check("sw_out_instr", out_instr, I_SW);
        tick();
        out_ready = 1'b0;

        // beq x0,x0,+8: x0 never hazards
        offer(32'h204, I_BEQ);
        @(negedge clk);
        check("beq_rf_r_en", rf_r_enabled, 1);
        check("beq_rf_rs1", rf_rs1, 0);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("beq_out_imm", out_imm, 8);
        check("beq_out_rd_used", out_rd_used, 0);
        tick();
        out_ready = 1'b0;

        // lui x5: U immediate, then mid-operation reset clears everything
        offer(32'h208, I_LUI);
        @(negedge clk);
        check("lui_rf_r_en", rf_r_enabled, 1);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("lui_out_imm", out_imm, 32'h1234_5000);
        check("lui_out_rd", out_rd, 5);
        tick();
        out_ready = 1'b0;
        offer(32'h300, I_ADDI_X1);
        @(negedge clk);
        check("lui_busy", dut.u_scoreboard.busy, 32'h20);
        tick();
        in_valid = 1'b0;
        rstn     = 1'b0;
        @(negedge clk);
        check("pre_rst_out_valid", out_valid, 1);
        tick();
        rstn = 1'b1;
        @(negedge clk);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_busy", dut.u_scoreboard.busy, 0);
        check("mid_rst_out_pc", out_pc, 0);
        tick();

        // without bypass the read happens one cycle after the writeback
        nb_in_valid = 1'b1;
        nb_in_pc    = 32'h400;
        nb_in_instr = I_ADDI_X1;
        tick();
        nb_in_valid  = 1'b0;
        nb_out_ready = 1'b1;
        @(negedge clk);
        check("nb_out_valid1", nb_out_valid, 1);
        tick();
        nb_out_ready = 1'b0;
        nb_in_valid  = 1'b1;
        nb_in_pc     = 32'h404;
        nb_in_instr  = I_ADD_X2;
        @(negedge clk);
        check("nb_raw_rf_r_en", nb_rf_r_enabled, 0);
        tick();
        nb_in_valid  = 1'b0;
        nb_wb_enable = 1'b1;
        nb_wb_addr   = 5'd1;
        @(negedge clk);
        check("nb_wb_cycle_rf_r_en", nb_rf_r_enabled, 0);
        tick();
        nb_wb_enable = 1'b0;
        @(negedge clk);
        check("nb_late_rf_r_en", nb_rf_r_enabled, 1);
        check("nb_late_rf_rs1", nb_rf_rs1, 1);
        tick();
        @(negedge clk);
        check("nb_out_valid2", nb_out_valid, 1);
        check("nb_out_rd", nb_out_rd, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
